traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Two-road intersection sequencer for the traffic-light design. It owns the phase timer and drives the lamp outputs for road A (main) and road B (side) through green, yellow and all-red phases. It also serves a latched pedestrian request by cutting main green short and asserting a walk signal, and implements a night-mode flashing-yellow state. Time advances only on an external one-cycle `tick` pulse from the system prescaler.

## Interface
- GREEN_A_TIME, 29: road A green end count (ticks)
- GREEN_B_TIME, 19: road B green end count
- YELLOW_TIME, 4: yellow end count (both roads)
- ALLRED_TIME, 2: all-red end count
- MIN_GREEN, 5: minimum A-green count before a pedestrian cut; must be ≤ GREEN_A_TIME; all times ≤ 255
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle time-base pulse
- ped_req  in  1  pedestrian button (any-cycle pulse or level)
- night_mode  in  1  request flashing-yellow operation
- a_red, a_yel, a_grn  out  1 each  road A lamps
- b_red, b_yel, b_grn  out  1 each  road B lamps
- ped_walk  out  1  pedestrian walk (crossing road A)
- remain  out  8  ticks remaining in current phase
- state  out  3  current state code

## Operation
- States/codes: A_GRN=0, A_YEL=1, AR1=2, B_GRN=3, B_YEL=4, AR2=5, FLASH=6; code 7 unreachable, recovers to AR2.
- Phase counter `cnt` (8 bit): increments on tick, cleared to 0 on every state change; no other wrap.
- Phase end: tick=1 and cnt == phase time (T); phase therefore lasts T+1 ticks. Next state on the same edge.
- Normal order: A_GRN→A_YEL→AR1→B_GRN→B_YEL→AR2→A_GRN.
- Lamps: A_GRN a_grn+b_red; A_YEL a_yel+b_red; AR1/AR2 a_red+b_red; B_GRN a_red+b_grn; B_YEL a_red+b_yel; FLASH a_yel=b_yel=blink, all else 0.
- Exactly one lamp per road lit outside FLASH; never green on both roads.
- Pedestrian: `ped_pend` set on any cycle ped_req=1. In A_GRN, tick with ped_pend=1 and cnt ≥ MIN_GREEN ends green early (→A_YEL).
- Entering B_GRN: ped_walk set if ped_pend=1, ped_pend cleared; ped_req in that same cycle wins (ped_pend stays 1). ped_walk cleared when leaving B_GRN.
- Night: night_mode=1 on a tick in A_GRN or B_GRN ends green immediately (ignores MIN_GREEN). Yellow runs full. At AR1/AR2 end with night_mode=1 → FLASH instead of the next green.
- FLASH: blink toggles each tick (starts 1 on entry); ped_pend cleared on entry and held 0. Tick with night_mode=0 → AR2 (cnt=0, full all-red before A_GRN).
- remain = T − cnt in timed states; 0 in FLASH.

## Timing
- Reset: state=AR2, cnt=0, ped_pend=0, ped_walk=0, blink=0; outputs a_red=b_red=1, others 0, remain=ALLRED_TIME, state=5.
- rst has priority over tick and all inputs.
- All state, cnt, ped_pend, ped_walk, blink registered; lamps/remain/state decode from registers only (no input-to-output combinational path).
- Outputs change the cycle after the tick edge that causes a transition.
- Without tick, nothing changes except ped_pend capture.

## Test plan
Params: GREEN_A=5, GREEN_B=3, YELLOW=2, ALLRED=1, MIN_GREEN=2; tick every cycle unless noted.
- Reset then free run, no requests → AR2 2, A_GRN 6, A_YEL 3, AR1 2, B_GRN 4, B_YEL 3 ticks; 20-tick period repeats; remain counts T..0; ped_walk stays 0.
- ped_req pulse at A_GRN cnt=0 → A_GRN lasts 3 ticks; ped_walk=1 for all 4 B_GRN ticks; ped_pend 0 afterwards.
- ped_req at A_GRN cnt=4 (≥MIN_GREEN) → A_YEL entered on the next tick; ped_req during B_GRN → served in following cycle, not current.
- night_mode=1 at A_GRN cnt=1 → A_YEL next tick, AR1 2 ticks, FLASH with a_yel=b_yel toggling per tick; release → AR2 2 ticks then A_GRN.
- tick held low 10 cycles mid A_GRN → state/remain frozen; ped_req still latched.
- rst asserted during B_GRN with ped_walk=1 → next cycle state=5, a_red=b_red=1, ped_walk=0, remain=1.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// traffic_light_ctrl : two-road light sequencer with pedestrian cut and night flash
// Rev 1.0
// ============================================================================
module traffic_light_ctrl #(
  parameter int unsigned GREEN_A_TIME = 29,
  parameter int unsigned GREEN_B_TIME = 19,
  parameter int unsigned YELLOW_TIME  = 4,
  parameter int unsigned ALLRED_TIME  = 2,
  parameter int unsigned MIN_GREEN    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic       a_red,
  output logic       a_yel,
  output logic       a_grn,
  output logic       b_red,
  output logic       b_yel,
  output logic       b_grn,
  output logic       ped_walk,
  output logic [7:0] remain,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR1   = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_t;

  localparam logic [7:0] C_T_GA   = 8'(GREEN_A_TIME);
  localparam logic [7:0] C_T_GB   = 8'(GREEN_B_TIME);
  localparam logic [7:0] C_T_YEL  = 8'(YELLOW_TIME);
  localparam logic [7:0] C_T_AR   = 8'(ALLRED_TIME);
  localparam logic [7:0] C_MIN_GR = 8'(MIN_GREEN);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_ped_pend;
  logic       r_ped_walk;
  logic       r_blink;
  logic [5:0] r_lamps;
  logic [7:0] r_remain;

  state_t     w_nstate;
  logic       w_phase_end;
  logic       w_enter_bgrn;
  logic [7:0] w_ncnt;
  logic       w_nped_pend;
  logic       w_nped_walk;
  logic       w_nblink;
  logic [5:0] w_nlamps;
  logic [7:0] w_nremain;

  function automatic logic [7:0] phase_time(input state_t s);
    logic [7:0] t;
    case (s)
      A_GRN:        t = C_T_GA;
      B_GRN:        t = C_T_GB;
      A_YEL, B_YEL: t = C_T_YEL;
      AR1, AR2:     t = C_T_AR;
      default:      t = 8'd0;
    endcase
    return t;
  endfunction

  always_comb begin
    w_phase_end = tick && (r_cnt == phase_time(r_state));
    w_nstate    = r_state;
    case (r_state)
      A_GRN: if (w_phase_end || (tick && (night_mode || (r_ped_pend && (r_cnt >= C_MIN_GR)))))
               w_nstate = A_YEL;
      A_YEL: if (w_phase_end) w_nstate = AR1;
      AR1:   if (w_phase_end) w_nstate = night_mode ? FLASH : B_GRN;
      B_GRN: if (w_phase_end || (tick && night_mode)) w_nstate = B_YEL;
      B_YEL: if (w_phase_end) w_nstate = AR2;
      AR2:   if (w_phase_end) w_nstate = night_mode ? FLASH : A_GRN;
      FLASH: if (tick && !night_mode) w_nstate = AR2;
      default: w_nstate = AR2;
    endcase
  end

  // A button press coincident with B_GRN entry belongs to the next crossing.
  always_comb begin
    w_enter_bgrn = (w_nstate == B_GRN) && (r_state != B_GRN);
    w_ncnt       = (w_nstate != r_state) ? 8'd0 : (tick ? r_cnt + 8'd1 : r_cnt);
    w_nped_pend  = r_ped_pend | ped_req;
    w_nped_walk  = r_ped_walk;
    if (w_nstate == FLASH) begin
      w_nped_pend = 1'b0;
    end else if (w_enter_bgrn) begin
      w_nped_pend = ped_req;
      w_nped_walk = r_ped_pend;
    end else if ((r_state == B_GRN) && (w_nstate != B_GRN)) begin
      w_nped_walk = 1'b0;
    end
    w_nblink = 1'b0;
    if (w_nstate == FLASH)
      w_nblink = (r_state != FLASH) ? 1'b1 : (r_blink ^ tick);
  end

  // Lamp order: {a_red, a_yel, a_grn, b_red, b_yel, b_grn}
  always_comb begin
    case (w_nstate)
      A_GRN:   w_nlamps = 6'b001_100;
      A_YEL:   w_nlamps = 6'b010_100;
      B_GRN:   w_nlamps = 6'b100_001;
      B_YEL:   w_nlamps = 6'b100_010;
      FLASH:   w_nlamps = {1'b0, w_nblink, 1'b0, 1'b0, w_nblink, 1'b0};
      default: w_nlamps = 6'b100_100;
    endcase
    w_nremain = (w_nstate == FLASH) ? 8'd0 : (phase_time(w_nstate) - w_ncnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= AR2;
      r_cnt      <= 8'd0;
      r_ped_pend <= 1'b0;
      r_ped_walk <= 1'b0;
      r_blink    <= 1'b0;
      r_lamps    <= 6'b100_100;
      r_remain   <= C_T_AR;
    end else begin
      r_state    <= w_nstate;
      r_cnt      <= w_ncnt;
      r_ped_pend <= w_nped_pend;
      r_ped_walk <= w_nped_walk;
      r_blink    <= w_nblink;
      r_lamps    <= w_nlamps;
      r_remain   <= w_nremain;
    end
  end

  assign {a_red, a_yel, a_grn, b_red, b_yel, b_grn} = r_lamps;
  assign ped_walk = r_ped_walk;
  assign remain   = r_remain;
  assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// tb_traffic_light_ctrl : scoreboard bench for the intersection sequencer
// Rev 1.0
// ============================================================================
module tb_traffic_light_ctrl;

  localparam int GA = 5, GB = 3, YT = 2, AT = 1, MG = 2;

  logic       clk = 1'b0;
  logic       rst, tick, ped_req, night_mode;
  logic       a_red, a_yel, a_grn, b_red, b_yel, b_grn, ped_walk;
  logic [7:0] remain;
  logic [2:0] state;

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .GREEN_A_TIME(GA), .GREEN_B_TIME(GB), .YELLOW_TIME(YT),
    .ALLRED_TIME(AT), .MIN_GREEN(MG)
  ) u_dut (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .night_mode(night_mode),
    .a_red(a_red), .a_yel(a_yel), .a_grn(a_grn),
    .b_red(b_red), .b_yel(b_yel), .b_grn(b_grn),
    .ped_walk(ped_walk), .remain(remain), .state(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] rem;
    logic [5:0] lamps;
    logic       walk;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model
  int m_st, m_cnt;
  bit m_pend, m_walk, m_blink;

  int hist[8];
  int walk_cnt;
  bit rec_en;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int ptime(input int s);
    case (s)
      0:       return GA;
      3:       return GB;
      1, 4:    return YT;
      2, 5:    return AT;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit t, input bit p, input bit n);
    int nx;
    int tt;
    if (r) begin
      m_st = 5; m_cnt = 0; m_pend = 0; m_walk = 0; m_blink = 0;
      return;
    end
    tt = ptime(m_st);
    nx = m_st;
    if (t) begin
      case (m_st)
        0: if (m_cnt == tt || n || (m_pend && m_cnt >= MG)) nx = 1;
        1: if (m_cnt == tt) nx = 2;
        2: if (m_cnt == tt) nx = n ? 6 : 3;
        3: if (m_cnt == tt || n) nx = 4;
        4: if (m_cnt == tt) nx = 5;
        5: if (m_cnt == tt) nx = n ? 6 : 0;
        6: if (!n) nx = 5;
        default: nx = 5;
      endcase
    end
    if (nx == 6) m_pend = 0;
    else if (nx == 3 && m_st != 3) begin
      m_walk = m_pend;
      m_pend = p;
    end else m_pend = m_pend | p;
    if (m_st == 3 && nx != 3) m_walk = 0;
    if (nx == 6 && m_st != 6) m_blink = 1;
    else if (nx == 6 && t) m_blink = !m_blink;
    else if (nx != 6) m_blink = 0;
    if (nx != m_st) m_cnt = 0;
    else if (t) m_cnt = (m_cnt + 1) % 256;
    m_st = nx;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.st   = 3'(m_st);
    e.rem  = (m_st == 6) ? 8'd0 : 8'(ptime(m_st) - m_cnt);
    e.walk = m_walk;
    case (m_st)
      0:       e.lamps = 6'b001_100;
      1:       e.lamps = 6'b010_100;
      3:       e.lamps = 6'b100_001;
      4:       e.lamps = 6'b100_010;
      6:       e.lamps = {1'b0, m_blink, 1'b0, 1'b0, m_blink, 1'b0};
      default: e.lamps = 6'b100_100;
    endcase
    return e;
  endfunction

  task automatic cycle(input bit r, input bit t, input bit p, input bit n);
    exp_t e;
    rst = r; tick = t; ped_req = p; night_mode = n;
    model_step(r, t, p, n);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val("state",  32'(state), 32'(e.st));
    check_val("remain", 32'(remain), 32'(e.rem));
    check_val("lamps",  32'({a_red, a_yel, a_grn, b_red, b_yel, b_grn}), 32'(e.lamps));
    check_val("walk",   32'(ped_walk), 32'(e.walk));
    if (state != 3'd6) begin
      check_val("a_onehot", $countones({a_red, a_yel, a_grn}), 1);
      check_val("b_onehot", $countones({b_red, b_yel, b_grn}), 1);
    end
    if (rec_en) begin
      hist[state]++;
      if (state == 3'd3 && ped_walk) walk_cnt++;
    end
  endtask

  task automatic clear_rec();
    foreach (hist[i]) hist[i] = 0;
    walk_cnt = 0;
  endtask

  task automatic run_to(input int st, input int cn, input bit n);
    int k;
    k = 0;
    while (!(m_st == st && m_cnt == cn) && k < 200) begin
      cycle(0, 1, 0, n);
      k++;
    end
    if (k >= 200) check_val("run_to_timeout", k, 0);
  endtask

  task automatic check_period(input string tag);
    check_val({tag, "_ar2"},  hist[5], 2);
    check_val({tag, "_agrn"}, hist[0], 6);
    check_val({tag, "_ayel"}, hist[1], 3);
    check_val({tag, "_ar1"},  hist[2], 2);
    check_val({tag, "_bgrn"}, hist[3], 4);
    check_val({tag, "_byel"}, hist[4], 3);
    check_val({tag, "_walk"}, walk_cnt, 0);
  endtask

  initial begin
    bit nm;
    rec_en = 0;
    clear_rec();
    rst = 1; tick = 0; ped_req = 0; night_mode = 0;

    // reset and free-running period
    cycle(1, 1, 0, 0);
    rec_en = 1;
    cycle(1, 1, 1, 1);
    check_val("rst_state", state, 5);
    check_val("rst_remain", remain, 1);
    check_val("rst_ared", a_red, 1);
    check_val("rst_bred", b_red, 1);
    check_val("rst_walk", ped_walk, 0);
    repeat (19) cycle(0, 1, 0, 0);
    rec_en = 0;
    check_period("period1");
    clear_rec();
    rec_en = 1;
    repeat (20) cycle(0, 1, 0, 0);
    rec_en = 0;
    check_period("period2");

    // pedestrian pulse at A_GRN cnt=0
    run_to(0, 0, 0);
    clear_rec();
    rec_en = 1;
    cycle(0, 1, 1, 0);
    run_to(5, 0, 0);
    rec_en = 0;
    check_val("ped_agrn_short", hist[0] + 1, 3);
    check_val("ped_bgrn_len", hist[3], 4);
    check_val("ped_walk_ticks", walk_cnt, 4);
    clear_rec();
    rec_en = 1;
    run_to(2, 0, 0);
    rec_en = 0;
    check_val("ped_cleared_agrn", hist[0], 6);

    // late pedestrian press, then press during B_GRN
    run_to(0, 4, 0);
    cycle(0, 1, 1, 0);
    check_val("late_ped_remain", remain, 0);
    cycle(0, 1, 0, 0);
    check_val("late_ped_ayel", state, 1);
    run_to(3, 1, 0);
    check_val("bgrn_walk_set", ped_walk, 1);
    cycle(0, 1, 1, 0);
    clear_rec();
    rec_en = 1;
    run_to(1, 0, 0);
    rec_en = 0;
    check_val("bgrn_press_next_cut", hist[0], 3);

    // night mode entry from A_GRN cnt=1, flashing, release
    run_to(0, 1, 0);
    cycle(0, 1, 0, 1);
    check_val("night_ayel", state, 1);
    run_to(6, 0, 1);
    check_val("flash_ayel0", a_yel, 1);
    check_val("flash_byel0", b_yel, 1);
    check_val("flash_ared", a_red, 0);
    cycle(0, 1, 1, 1);
    check_val("flash_ayel1", a_yel, 0);
    cycle(0, 1, 0, 1);
    check_val("flash_ayel2", a_yel, 1);
    cycle(0, 1, 0, 0);
    check_val("flash_exit_state", state, 5);
    check_val("flash_exit_remain", remain, 1);
    cycle(0, 1, 0, 0);
    check_val("flash_exit_ar2b", state, 5);
    cycle(0, 1, 0, 0);
    check_val("flash_exit_agrn", state, 0);
    check_val("flash_no_pend_remain", remain, 5);

    // tick held low mid A_GRN with a press during the freeze
    run_to(0, 1, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, (i == 4), 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check_val("freeze_ped_cut", state, 1);

    // reset while walking
    run_to(0, 0, 0);
    cycle(0, 1, 1, 0);
    run_to(3, 1, 0);
    check_val("pre_rst_walk", ped_walk, 1);
    cycle(1, 1, 1, 0);
    check_val("mid_rst_state", state, 5);
    check_val("mid_rst_lamps", {a_red, a_yel, a_grn, b_red, b_yel, b_grn}, 6'b100_100);
    check_val("mid_rst_walk", ped_walk, 0);
    check_val("mid_rst_remain", remain, 1);

    // random traffic
    nm = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) nm = !nm;
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 11) == 0), nm);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
